// File: rtl/dac_pkg.sv
// Shared widths, mode encodings and FSM/phase enums for the DAC wave sequencer.
// Optional output clamp in the top is enabled by DAC_WAVE_CLAMP_EN.
package dac_pkg;

  localparam int DAC_W = 12;
  localparam logic [DAC_W-1:0] DAC_MAX = 12'd4095;

  localparam logic [1:0] MODE_CONST  = 2'd0;
  localparam logic [1:0] MODE_SAW    = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;
  localparam logic [1:0] MODE_SQUARE = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  typedef enum logic {
    SQ_LOW  = 1'b0,
    SQ_HIGH = 1'b1
  } sq_phase_e;

endpackage

// File: rtl/dac_rate_div.sv
// Sample-period divider: ticks on the first run cycle, then once every max(period,1) clocks.
module dac_rate_div #(
  parameter int DIV_W = 16
) (
  input  logic             clk_X4,
  input  logic             rst_n,
  input  logic             run,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic [DIV_W-1:0] last_cnt;

  // A period of 0 behaves like 1, so the last count is 0 in both cases.
  assign last_cnt = (period == '0) ? '0 : period - 1'b1;

  always_comb begin
    div_d = div_q;
    if (!run) begin
      div_d = '0;
    end else if (div_q >= last_cnt) begin
      div_d = '0;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk_X4) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign tick = run && (div_q == '0);

endmodule

// File: rtl/dac_wave_sequencer.sv
// Periodic DAC sample generator (const/saw/tri/square) with valid/ready output and underrun flag.
// Define DAC_WAVE_CLAMP_EN to clamp the emitted code to [CLAMP_LO, CLAMP_HI].
module dac_wave_sequencer
  import dac_pkg::*;
#(
  parameter int DIV_W    = 16,
  parameter int CLAMP_LO = 0,
  parameter int CLAMP_HI = 4095
) (
  input  logic             clk_X4,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [DAC_W-1:0] step,
  input  logic [DAC_W-1:0] level,
  input  logic [DIV_W-1:0] period,
  output logic [DAC_W-1:0] sample_data,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             underrun,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [DAC_W-1:0] acc_q, acc_d;
  dir_e             dir_q, dir_d;
  sq_phase_e        sq_q, sq_d;
  logic [DAC_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             underrun_q, underrun_d;

  logic             run;
  logic             tick;
  logic [DAC_W-1:0] wave_val;
  logic [DAC_W-1:0] out_val;
  logic [DAC_W-1:0] acc_nx;
  dir_e             dir_nx;
  sq_phase_e        sq_nx;
  logic [DAC_W:0]   tri_sum;

  // Gating with enable keeps a tick from loading a sample on the cycle RUN is left.
  assign run = (state_q == RUN) && enable;

  dac_rate_div #(.DIV_W(DIV_W)) u_rate_div (
    .clk_X4 (clk_X4),
    .rst_n  (rst_n),
    .run    (run),
    .period (period),
    .tick   (tick)
  );

  assign tri_sum = {1'b0, acc_q} + {1'b0, step};

  always_comb begin
    wave_val = acc_q;
    acc_nx   = acc_q;
    dir_nx   = dir_q;
    sq_nx    = sq_q;
    case (mode)
      MODE_CONST: wave_val = level;
      MODE_SAW:   acc_nx = acc_q + step;
      MODE_TRI: begin
        if (dir_q == DIR_UP) begin
          if (tri_sum >= {1'b0, DAC_MAX}) begin
            acc_nx = DAC_MAX;
            dir_nx = DIR_DOWN;
          end else begin
            acc_nx = tri_sum[DAC_W-1:0];
          end
        end else begin
          if (acc_q <= step) begin
            acc_nx = '0;
            dir_nx = DIR_UP;
          end else begin
            acc_nx = acc_q - step;
          end
        end
      end
      default: begin
        wave_val = (sq_q == SQ_HIGH) ? level : '0;
        sq_nx    = (sq_q == SQ_HIGH) ? SQ_LOW : SQ_HIGH;
      end
    endcase
  end

`ifdef DAC_WAVE_CLAMP_EN
  localparam logic [DAC_W-1:0] LO_C = DAC_W'(CLAMP_LO);
  localparam logic [DAC_W-1:0] HI_C = DAC_W'(CLAMP_HI);
  // Clamp only the emitted code; the accumulator keeps its full range.
  always_comb begin
    out_val = wave_val;
    if (out_val < LO_C) out_val = LO_C;
    if (out_val > HI_C) out_val = HI_C;
  end
`else
  assign out_val = wave_val;
  // Empty marker block: an inverted clamp range shows up in the elaborated hierarchy.
  if (CLAMP_LO > CLAMP_HI) begin : g_clamp_range_inverted
  end
`endif

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    dir_d      = dir_q;
    sq_d       = sq_q;
    data_d     = data_q;
    valid_d    = valid_q;
    underrun_d = 1'b0;

    if (valid_q && sample_ready) valid_d = 1'b0;

    if (tick) begin
      if (!valid_q || sample_ready) begin
        data_d  = out_val;
        valid_d = 1'b1;
        acc_d   = acc_nx;
        dir_d   = dir_nx;
        sq_d    = sq_nx;
      end else begin
        underrun_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RUN;
          acc_d   = '0;
          dir_d   = DIR_UP;
          sq_d    = SQ_HIGH;
        end
      end
      RUN: begin
        if (!enable) state_d = valid_q ? DRAIN : IDLE;
      end
      DRAIN: begin
        // Also leave if the pending sample went out on the cycle RUN was exited.
        if (!valid_q || sample_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_X4) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      dir_q      <= DIR_UP;
      sq_q       <= SQ_HIGH;
      data_q     <= '0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      dir_q      <= dir_d;
      sq_q       <= sq_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
    end
  end

  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign underrun     = underrun_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_dac_wave_sequencer.sv
// Directed bench for dac_wave_sequencer; expectations follow the clamp when DAC_WAVE_CLAMP_EN is set.
module tb_dac_wave_sequencer;

  logic        clk_X4 = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [1:0]  mode;
  logic [11:0] step;
  logic [11:0] level;
  logic [15:0] period;
  logic [11:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        underrun;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int xq[$];
  int tq[$];

  always #5 clk_X4 = ~clk_X4;

  dac_wave_sequencer #(.DIV_W(16), .CLAMP_LO(100), .CLAMP_HI(3000)) dut (
    .clk_X4       (clk_X4),
    .rst_n        (rst_n),
    .enable       (enable),
    .mode         (mode),
    .step         (step),
    .level        (level),
    .period       (period),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .underrun     (underrun),
    .busy         (busy)
  );

  always @(posedge clk_X4) begin
    cyc <= cyc + 1;
    if (rst_n && sample_valid && sample_ready) begin
      xq.push_back(int'(sample_data));
      tq.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_code(input int v);
`ifdef DAC_WAVE_CLAMP_EN
    if (v < 100) return 100;
    if (v > 3000) return 3000;
`endif
    return v;
  endfunction

  task automatic wait_valid(input string tag, input int budget);
    int k;
    k = 0;
    while (!sample_valid && k < budget) begin
      @(negedge clk_X4);
      k++;
    end
    if (!sample_valid) check({tag, "_valid_timeout"}, 0, 1);
  endtask

  task automatic wait_xfers(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (xq.size() < n && k < budget) begin
      @(negedge clk_X4);
      k++;
    end
    if (xq.size() < n) check({tag, "_xfer_timeout"}, xq.size(), n);
  endtask

  task automatic stop_and_idle(input string tag);
    int k;
    enable = 1'b0;
    sample_ready = 1'b1;
    k = 0;
    @(negedge clk_X4);
    while (busy && k < 50) begin
      @(negedge clk_X4);
      k++;
    end
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic start(input logic [1:0] m, input int st, input int lv, input int per, input logic rdy);
    mode = m;
    step = 12'(st);
    level = 12'(lv);
    period = 16'(per);
    sample_ready = rdy;
    xq.delete();
    tq.delete();
    enable = 1'b1;
  endtask

  task automatic check_seq(input string tag, input int exp[], input int gap);
    for (int i = 0; i < exp.size(); i++) begin
      if (i < xq.size()) begin
        check($sformatf("%s_d%0d", tag, i), xq[i], exp_code(exp[i]));
        if (i > 0 && gap > 0)
          check($sformatf("%s_gap%0d", tag, i), tq[i] - tq[i-1], gap);
      end
    end
  endtask

  initial begin
    int saw_exp[];
    int tri_exp[];
    int sq_exp[];
    int cst_exp[];
    int cnt_ur;
    int cnt_hold;
    int cnt_busy;
    int cnt_valid;

    rst_n = 1'b0; enable = 1'b0; mode = 2'd0; step = '0; level = '0;
    period = '0; sample_ready = 1'b0;
    repeat (3) @(negedge clk_X4);
    check("rst_valid", sample_valid, 0);
    check("rst_data", sample_data, 0);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);
    rst_n = 1'b1;

    // Reset in the middle of a pending sample
    start(2'd1, 1000, 0, 4, 1'b0);
    @(negedge clk_X4);
    wait_valid("t1", 20);
    check("t1_pre_valid", sample_valid, 1);
    check("t1_pre_busy", busy, 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk_X4);
    check("t1_valid", sample_valid, 0);
    check("t1_data", sample_data, 0);
    check("t1_busy", busy, 0);
    check("t1_underrun", underrun, 0);
    enable = 1'b0;
    @(negedge clk_X4);
    rst_n = 1'b1;
    @(negedge clk_X4);
    check("t1_after_busy", busy, 0);

    // Sawtooth with wrap, one sample every 4 clocks
    saw_exp = '{0, 1000, 2000, 3000, 4000, 904};
    start(2'd1, 1000, 0, 4, 1'b1);
    wait_xfers("saw", 6, 80);
    check_seq("saw", saw_exp, 4);
    stop_and_idle("saw");

    // Triangle, turning at both ends
    tri_exp = '{0, 1500, 3000, 4095, 2595, 1095, 0, 1500};
    start(2'd2, 1500, 0, 2, 1'b1);
    wait_xfers("tri", 8, 80);
    check_seq("tri", tri_exp, 2);
    stop_and_idle("tri");

    // Square, period 1: new sample every cycle while ready stays high
    sq_exp = '{2000, 0, 2000, 0};
    start(2'd3, 77, 2000, 1, 1'b1);
    wait_xfers("sq", 4, 40);
    check_seq("sq", sq_exp, 1);
    stop_and_idle("sq");

    // Constant, period 0 behaves like 1
    cst_exp = '{77, 77, 77};
    start(2'd0, 500, 77, 0, 1'b1);
    wait_xfers("cst", 3, 40);
    check_seq("cst", cst_exp, 1);
    stop_and_idle("cst");

    // Backpressure: held data, underrun on every later tick, no acc advance
    start(2'd1, 1000, 0, 2, 1'b0);
    @(negedge clk_X4);
    wait_valid("bp", 20);
    cnt_ur = 0;
    cnt_hold = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_X4);
      if (underrun) cnt_ur++;
      if (sample_valid && sample_data == 12'(exp_code(0))) cnt_hold++;
    end
    check("bp_underruns", cnt_ur, 4);
    check("bp_held", cnt_hold, 8);
    xq.delete();
    tq.delete();
    sample_ready = 1'b1;
    wait_xfers("bp", 2, 20);
    if (xq.size() >= 2) begin
      check("bp_first", xq[0], exp_code(0));
      check("bp_next", xq[1], exp_code(1000));
    end
    stop_and_idle("bp");

    // Disable while a sample is pending: drain then idle
    start(2'd1, 1000, 0, 3, 1'b0);
    @(negedge clk_X4);
    wait_valid("dr", 20);
    enable = 1'b0;
    @(negedge clk_X4);
    check("dr_busy", busy, 1);
    check("dr_valid", sample_valid, 1);
    cnt_ur = 0;
    cnt_busy = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_X4);
      if (underrun) cnt_ur++;
      if (busy) cnt_busy++;
    end
    check("dr_no_underrun", cnt_ur, 0);
    check("dr_busy_hold", cnt_busy, 5);
    sample_ready = 1'b1;
    @(negedge clk_X4);
    check("dr_valid_drop", sample_valid, 0);
    check("dr_idle", busy, 0);
    cnt_valid = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_X4);
      if (sample_valid) cnt_valid++;
    end
    check("dr_no_more_valid", cnt_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
